// File: rtl/if_fetch_unit_pkg.sv
// Shared pipeline definitions used by the instruction-fetch stage.
package if_fetch_unit_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DROP  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage feeding the IF/ID register. One request to
// instruction memory is outstanding at a time. Responses to addresses
// abandoned by a redirect are swallowed.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | first cycle after reset, no request issued
// FETCH | request at pc_q; the response is presented in the same cycle
// HOLD  | response captured while stalled, replayed from hold_instr_q
// DROP  | waiting out a wrong-path response at drop_addr_q
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stallF,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] PC_out,
  output logic [XLEN-1:0] PCplus4_out,
  output logic [XLEN-1:0] instruction_out,
  output logic            fetch_valid
);

  fetch_state_t    state, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] drop_addr_q, drop_addr_d;
  logic [XLEN-1:0] hold_instr_q, hold_instr_d;
  logic [XLEN-1:0] redirect_pc;

  // Targets are always word aligned; the low two bits are ignored.
  assign redirect_pc = {redirect_target[XLEN-1:2], 2'b00};

  // The presented PC is always the fetch PC register.
  assign PC_out      = pc_q;
  assign PCplus4_out = pc_q + 32'd4;

  // Next-state, register updates and memory/pipeline outputs.
  always_comb begin
    state_d         = state;
    pc_d            = pc_q;
    drop_addr_d     = drop_addr_q;
    hold_instr_d    = hold_instr_q;
    imem_req        = 1'b0;
    imem_addr       = pc_q;
    fetch_valid     = 1'b0;
    instruction_out = NOP_INSTR;

    case (state)
      IDLE: begin
        state_d = FETCH;
      end

      FETCH: begin
        imem_req = 1'b1;
        if (imem_rvalid && !redirect) begin
          fetch_valid     = 1'b1;
          instruction_out = imem_rdata;
          if (stallF) begin
            hold_instr_d = imem_rdata;
            state_d      = HOLD;
          end else begin
            pc_d = pc_q + 32'd4;
          end
        end else if (!imem_rvalid && redirect) begin
          // Response still owed for pc_q; remember it so the address stays put.
          drop_addr_d = pc_q;
          state_d     = DROP;
        end
      end

      HOLD: begin
        fetch_valid     = 1'b1;
        instruction_out = hold_instr_q;
        if (redirect) begin
          state_d = FETCH;
        end else if (!stallF) begin
          pc_d    = pc_q + 32'd4;
          state_d = FETCH;
        end
      end

      DROP: begin
        imem_req  = 1'b1;
        imem_addr = drop_addr_q;
        if (imem_rvalid) begin
          state_d = FETCH;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // A redirect beats everything else for the next fetch PC.
    if (redirect) begin
      pc_d = redirect_pc;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      pc_q         <= RESET_PC;
      drop_addr_q  <= '0;
      hold_instr_q <= NOP_INSTR;
    end else begin
      state        <= state_d;
      pc_q         <= pc_d;
      drop_addr_q  <= drop_addr_d;
      hold_instr_q <= hold_instr_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomized bench for if_fetch_unit against a transaction-level model,
// plus a second instance with RESET_PC at the top of the address space.
module tb_if_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

  logic        clk;
  logic        reset;
  logic        stallF;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] PC_out;
  logic [31:0] PCplus4_out;
  logic [31:0] instruction_out;
  logic        fetch_valid;

  logic        w_reset;
  logic        w_req;
  logic [31:0] w_addr;
  logic        w_rvalid;
  logic [31:0] w_rdata;
  logic [31:0] w_pc;
  logic [31:0] w_pc4;
  logic [31:0] w_instr;
  logic        w_fv;

  int n_checks = 0;
  int n_fail   = 0;
  bit wrap_done = 0;

  if_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk             (clk),
    .reset           (reset),
    .stallF          (stallF),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .PC_out          (PC_out),
    .PCplus4_out     (PCplus4_out),
    .instruction_out (instruction_out),
    .fetch_valid     (fetch_valid)
  );

  // Zero-wait memory returning the address as data.
  assign w_rvalid = w_req;
  assign w_rdata  = w_addr;

  if_fetch_unit #(.RESET_PC(WRAP_PC)) dut_wrap (
    .clk             (clk),
    .reset           (w_reset),
    .stallF          (1'b0),
    .redirect        (1'b0),
    .redirect_target (32'h0),
    .imem_req        (w_req),
    .imem_addr       (w_addr),
    .imem_rvalid     (w_rvalid),
    .imem_rdata      (w_rdata),
    .PC_out          (w_pc),
    .PCplus4_out     (w_pc4),
    .instruction_out (w_instr),
    .fetch_valid     (w_fv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- memory model with configurable wait states
  int         mem_mode;   // 0: zero wait, 1: two waits, 2: random 0..3
  logic [2:0] mem_cnt;
  logic [2:0] mem_wait;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000 ^ {a[7:0], 24'h0};
  endfunction

  function automatic logic [2:0] pick_wait();
    if (mem_mode == 0) return 3'd0;
    if (mem_mode == 1) return 3'd2;
    return 3'($urandom_range(0, 3));
  endfunction

  assign imem_rvalid = imem_req && (mem_cnt == mem_wait);
  assign imem_rdata  = imem_rvalid ? mem_word(imem_addr) : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (reset || !imem_req || imem_rvalid) begin
      mem_cnt  <= 3'd0;
      mem_wait <= pick_wait();
    end else begin
      mem_cnt <= mem_cnt + 3'd1;
    end
  end

  // ---------------- reference model
  // m_pc: address of the next instruction in program order
  // m_started: a request may be issued (false for one cycle after reset)
  // m_held: an instruction was presented under stall and is being replayed
  // m_stale: a wrong-path response is still owed at m_stale_addr
  logic [31:0] m_pc;
  bit          m_started;
  bit          m_held;
  logic [31:0] m_held_instr;
  bit          m_stale;
  logic [31:0] m_stale_addr;

  task automatic model_reset();
    m_pc      = RST_PC;
    m_started = 0;
    m_held    = 0;
    m_stale   = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    stallF   = 1'b0;
    redirect = 1'b0;
    #1;
    model_reset();
    chk_val("rst_req",   {31'b0, imem_req},    32'd0);
    chk_val("rst_fv",    {31'b0, fetch_valid}, 32'd0);
    chk_val("rst_instr", instruction_out,      32'h0);
    chk_val("rst_pc",    PC_out,               RST_PC);
    chk_val("rst_pc4",   PCplus4_out,          RST_PC + 32'd4);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic step(input int stall_pct, input int redir_pct);
    logic        e_req, e_fv, rv;
    logic [31:0] e_addr, e_instr;
    @(negedge clk);
    stallF          = ($urandom_range(0, 99) < stall_pct);
    redirect        = ($urandom_range(0, 99) < redir_pct);
    redirect_target = $urandom;
    #1;
    e_req   = m_started && !m_held;
    e_addr  = m_stale ? m_stale_addr : m_pc;
    rv      = e_req && (mem_cnt == mem_wait);
    e_fv    = 1'b0;
    e_instr = 32'h0;
    if (m_held) begin
      e_fv    = 1'b1;
      e_instr = m_held_instr;
    end else if (e_req && !m_stale && rv && !redirect) begin
      e_fv    = 1'b1;
      e_instr = mem_word(m_pc);
    end

    chk_val("req", {31'b0, imem_req}, {31'b0, e_req});
    if (e_req) chk_val("addr", imem_addr, e_addr);
    chk_val("fv", {31'b0, fetch_valid}, {31'b0, e_fv});
    chk_val("instr", instruction_out, e_instr);
    if (e_fv || !m_started) begin
      chk_val("pc",  PC_out,      m_pc);
      chk_val("pc4", PCplus4_out, m_pc + 32'd4);
    end

    // advance the model to the next cycle
    if (redirect) begin
      if (m_started && !m_held && !rv) begin
        if (!m_stale) m_stale_addr = m_pc;
        m_stale = 1;
      end else begin
        m_stale = 0;
      end
      m_held = 0;
      m_pc   = redirect_target & 32'hFFFF_FFFC;
    end else if (m_held) begin
      if (!stallF) begin
        m_held = 0;
        m_pc   = m_pc + 32'd4;
      end
    end else if (m_stale) begin
      if (rv) m_stale = 0;
    end else if (m_started && rv) begin
      if (stallF) begin
        m_held       = 1;
        m_held_instr = mem_word(m_pc);
      end else begin
        m_pc = m_pc + 32'd4;
      end
    end
    m_started = 1;
  endtask

  // ---------------- main stimulus
  initial begin
    reset           = 1'b1;
    stallF          = 1'b0;
    redirect        = 1'b0;
    redirect_target = 32'h0;
    mem_mode        = 0;
    model_reset();
    do_reset();

    for (int i = 0; i < 100; i++) step(0, 0);
    mem_mode = 1;
    for (int i = 0; i < 150; i++) step(0, 0);
    for (int i = 0; i < 150; i++) step(25, 0);
    for (int i = 0; i < 200; i++) step(25, 8);
    mem_mode = 2;
    for (int i = 0; i < 1000; i++) step(30, 10);
    do_reset();
    for (int i = 0; i < 1000; i++) step(40, 15);
    mem_mode = 0;
    for (int i = 0; i < 300; i++) step(30, 10);

    for (int i = 0; i < 20 && !wrap_done; i++) @(negedge clk);
    chk_val("wrap_done", {31'b0, wrap_done}, 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // ---------------- RESET_PC at the top of memory wraps to 0
  initial begin
    w_reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk_val("w_rst_pc",  w_pc,  WRAP_PC);
    chk_val("w_rst_pc4", w_pc4, 32'h0);
    @(posedge clk);
    #1 w_reset = 1'b0;
    @(negedge clk); #1;
    chk_val("w_idle_req", {31'b0, w_req}, 32'd0);
    @(negedge clk); #1;
    chk_val("w_f0_fv",    {31'b0, w_fv}, 32'd1);
    chk_val("w_f0_pc",    w_pc,    WRAP_PC);
    chk_val("w_f0_pc4",   w_pc4,   32'h0);
    chk_val("w_f0_instr", w_instr, WRAP_PC);
    @(negedge clk); #1;
    chk_val("w_f1_addr",  w_addr,  32'h0);
    chk_val("w_f1_pc",    w_pc,    32'h0);
    chk_val("w_f1_instr", w_instr, 32'h0);
    chk_val("w_f1_pc4",   w_pc4,   32'h4);
    wrap_done = 1;
  end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage that drives the IF/ID pipeline register. Owns the program counter, issues one-outstanding-at-a-time requests to instruction memory, and presents `PC_out`, `PCplus4_out` and `instruction_out` with a `fetch_valid` qualifier. Honours `stallF` from the hazard unit and branch/jump redirects resolved in EX, discarding wrong-path responses.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `clk` input 1: sole clock, rising edge.
- `reset` input 1: asynchronous, active-high.
- `stallF` input 1: hold the presented instruction and PC.
- `redirect` input 1: taken branch/jump from EX.
- `redirect_target` input 32: new PC; bits [1:0] are ignored and treated as 0.
- `imem_req` output 1: request valid, held until `imem_rvalid`.
- `imem_addr` output 32: request address, stable while `imem_req`=1.
- `imem_rvalid` input 1: response valid; may arrive in the request cycle or later.
- `imem_rdata` input 32: instruction word, valid with `imem_rvalid`.
- `PC_out` output 32: PC of the presented instruction.
- `PCplus4_out` output 32: `PC_out`+4, modulo 2^32.
- `instruction_out` output 32: presented instruction; 32'h0 (NOP) when `fetch_valid`=0.
- `fetch_valid` output 1: the instruction is real; the hazard unit treats 0 as a bubble.

## Operation
- Registers: `pc_q` (next fetch PC), `drop_addr_q`, `hold_instr_q`, `state`.
- States: IDLE, FETCH, HOLD, DROP.
- Reset:
  - state=IDLE, `pc_q`=RESET_PC.
  - Outputs: `imem_req`=0, `fetch_valid`=0, `instruction_out`=0, `PC_out`=RESET_PC, `PCplus4_out`=RESET_PC+4.
- IDLE: goes to FETCH on the next edge, unconditionally.
- FETCH: `imem_req`=1, `imem_addr`=`pc_q`, `PC_out`=`pc_q`.
  - `imem_rvalid`=1: `fetch_valid`=1 and `instruction_out`=`imem_rdata` in the same cycle (bypass).
    - `stallF`=0: `pc_q`←`pc_q`+4; stay in FETCH.
    - `stallF`=1: `hold_instr_q`←`imem_rdata`; go to HOLD.
  - `imem_rvalid`=0: `fetch_valid`=0 and `instruction_out`=0.
- HOLD: `imem_req`=0, `fetch_valid`=1, `instruction_out`=`hold_instr_q`, `PC_out`=`pc_q`.
  - `stallF`=0: `pc_q`←`pc_q`+4; go to FETCH.
- DROP: `imem_req`=1, `imem_addr`=`drop_addr_q`, `fetch_valid`=0.
  - `imem_rvalid`=1: response is discarded; go to FETCH.
- Redirect (highest priority, overrides `stallF`): `pc_q`←{`redirect_target`[31:2],2'b00}.
  - From IDLE or HOLD: go to FETCH; any held instruction is discarded.
  - From FETCH with `imem_rvalid`=1: response discarded; `fetch_valid` is forced 0 that cycle; go to FETCH.
  - From FETCH with `imem_rvalid`=0: `drop_addr_q`←`pc_q`; go to DROP.
  - From DROP with `imem_rvalid`=0: stay in DROP; `drop_addr_q` is unchanged.
  - From DROP with `imem_rvalid`=1: go to FETCH.
- Arithmetic: PC increment wraps modulo 2^32 (32'hFFFF_FFFC → 32'h0).
- Memory protocol: at most one outstanding request. The address never changes while a request is pending.

## Timing
- Zero-wait memory (`imem_rvalid` in the request cycle): 1 instruction/cycle, 0-cycle fetch latency from `pc_q`.
- N-wait memory: an instruction is presented in the `imem_rvalid` cycle; `fetch_valid`=0 for the N preceding cycles.
- Redirect at edge t: the first target request is issued in cycle t+1 if no response is pending. Otherwise it is issued the cycle after the discarded response.
- Consumption edge: `fetch_valid`=1 and `stallF`=0. IF/ID captures on this same edge.
- Reset asserted mid-request: the pending response is abandoned. The memory must tolerate the deasserted request.

## Structure
- Shared pipeline package holds:
  - state encoding constants (IDLE/FETCH/HOLD/DROP, 2 bits);
  - `NOP_INSTR`=32'h0;
  - `XLEN`=32;
  - `RESET_PC` default.
- No sub-module: PC register, hold register and FSM stay in one module.

## Test plan
- Reset then zero-wait memory returning `addr` as data, `stallF`=0 → `PC_out` 0,4,8,12 on consecutive cycles, `instruction_out` equal to `PC_out`, `fetch_valid`=1 from the first FETCH cycle.
- 2-wait memory → `fetch_valid` pattern 0,0,1 repeating; `imem_addr` stable across wait cycles.
- `stallF`=1 for 3 cycles while PC=0x8 is presented → `PC_out`=0x8 and the same instruction held, `imem_req`=0; fetch resumes at 0xC.
- `redirect`=1, target 0x103 (low bits ignored), during a 3-wait request to 0x10 → DROP; `imem_addr`=0x10 until rvalid, data discarded (`fetch_valid`=0), next request to 0x100.
- Redirect coincident with `stallF`=1 in HOLD → held instruction dropped, next request at the target.
- `RESET_PC`=32'hFFFF_FFFC → second fetch address 0x0, `PCplus4_out`=0x0 for the first instruction.
